// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory request unit
package cpu_types_pkg;
   typedef enum logic [1:0] {RQ_IDLE, RQ_DATA, RQ_HALT} reqstate_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear up counter that holds at MAX
module sat_counter #(
   parameter int W = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         at_max
);
   assign at_max = q == MAX;
   always_ff @(posedge clk)
      if (clear) q <= '0;
      else if (inc && !at_max) q <= q + W'(1);
endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: turns control-unit memory intent into held fetch/data requests on one port,
// stalls the PC until the matching hit, latches halt and keeps stall/timeout statistics
module mem_request_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             Iren,
   input  logic             Dren,
   input  logic             Dwen,
   input  logic             halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             req_err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   reqstate_t state, next_state;
   logic go_data, go_halt, err, t_inc, t_max, s_max;
   logic [TW-1:0] t_q;
   always_comb begin
      next_state = state;
      imemREN    = 1'b0;
      pc_en      = 1'b0;
      go_data    = 1'b0;
      go_halt    = 1'b0;
      err        = 1'b0;
      case (state)
         RQ_IDLE: begin
            imemREN    = Iren;
            pc_en      = ihit & ~(Dren | Dwen) & ~halt;
            go_halt    = ihit & halt;
            go_data    = ihit & ~halt & (Dren | Dwen);
            err        = (go_halt & (Dren | Dwen)) | (go_data & Dren & Dwen);
            next_state = go_halt ? RQ_HALT : go_data ? RQ_DATA : RQ_IDLE;
         end
         RQ_DATA: begin
            pc_en      = dhit;
            next_state = dhit ? RQ_IDLE : RQ_DATA;
         end
         default: ;
      endcase
   end
   always_ff @(posedge CLK)
      if (!nRST) state <= RQ_IDLE;
      else state <= next_state;
   // Data request is latched at fetch time so later control changes cannot disturb it
   always_ff @(posedge CLK)
      if (!nRST || (state == RQ_DATA && dhit)) begin
         dmemREN <= 1'b0;
         dmemWEN <= 1'b0;
      end else if (go_data) begin
         dmemREN <= Dren & ~Dwen;
         dmemWEN <= Dwen;
      end
   assign halted = state == RQ_HALT;
   assign t_inc  = (state == RQ_DATA) & ~dhit & ~t_max;
   always_ff @(posedge CLK)
      req_err <= nRST & (err | (t_inc & (t_q == T_LAST)));
   sat_counter #(.W(CNT_W)) u_stall (
      .clk(CLK), .clear(~nRST), .inc(~pc_en & ~halted & ~s_max), .q(stall_cnt), .at_max(s_max)
   );
   sat_counter #(.W(TW), .MAX(TW'(TIMEOUT))) u_tout (
      .clk(CLK), .clear(~nRST | go_data), .inc(t_inc), .q(t_q), .at_max(t_max)
   );
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed stimulus, transaction-level reference model checked every cycle
module tb_mem_request_unit;
   localparam int CNT_W = 5, TIMEOUT = 4, SMAX = 31;
   logic CLK = 0, nRST = 0, Iren = 0, Dren = 0, Dwen = 0, halt = 0, ihit = 0, dhit = 0;
   logic imemREN, dmemREN, dmemWEN, pc_en, halted, req_err;
   logic [CNT_W-1:0] stall_cnt;
   int n_tests = 0, n_fail = 0;
   always #5 CLK = ~CLK;
   mem_request_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST), .Iren(Iren), .Dren(Dren), .Dwen(Dwen), .halt(halt),
      .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .pc_en(pc_en), .halted(halted), .stall_cnt(stall_cnt), .req_err(req_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: whether an instruction is waiting on data, what it asked for, how long it waited
   bit mvalid, m_busy, m_halt, m_rd, m_wr, m_err;
   int m_wait, m_stall;
   always @(negedge CLK) begin
      bit e_imem, e_pc, err;
      e_imem = !m_halt && !m_busy && Iren;
      e_pc   = m_halt ? 1'b0 : m_busy ? dhit : (ihit && !Dren && !Dwen && !halt);
      if (mvalid) begin
         chk("m_imemREN", {31'b0, imemREN}, int'(e_imem));
         chk("m_pc_en", {31'b0, pc_en}, int'(e_pc));
         chk("m_dmemREN", {31'b0, dmemREN}, int'(m_rd));
         chk("m_dmemWEN", {31'b0, dmemWEN}, int'(m_wr));
         chk("m_halted", {31'b0, halted}, int'(m_halt));
         chk("m_req_err", {31'b0, req_err}, int'(m_err));
         chk("m_stall_cnt", {27'b0, stall_cnt}, m_stall);
      end
      if (!nRST) begin
         {m_busy, m_halt, m_rd, m_wr, m_err} = '0;
         m_wait = 0;
         m_stall = 0;
         mvalid = 1;
      end else if (mvalid) begin
         err = 0;
         if (!e_pc && !m_halt) m_stall = m_stall < SMAX ? m_stall + 1 : SMAX;
         if (m_halt) ;
         else if (!m_busy) begin
            if (ihit && halt) begin
               m_halt = 1;
               err = Dren || Dwen;
            end else if (ihit && (Dren || Dwen)) begin
               m_busy = 1;
               m_rd = Dren && !Dwen;
               m_wr = Dwen;
               m_wait = 0;
               err = Dren && Dwen;
            end
         end else if (dhit) begin
            m_busy = 0;
            m_rd = 0;
            m_wr = 0;
         end else if (m_wait < TIMEOUT) begin
            m_wait++;
            err = m_wait == TIMEOUT;
         end
         m_err = err;
      end
   end
   task automatic cyc(input bit rn, ir, dr, dw, hl, ih, dh);
      @(posedge CLK);
      #1;
      {nRST, Iren, Dren, Dwen, halt, ihit, dhit} = {rn, ir, dr, dw, hl, ih, dh};
      #2;
   endtask
   task automatic rst1();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      int pulses, first;
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("rst_imemREN", {31'b0, imemREN}, 1);
      chk("rst_dmemREN", {31'b0, dmemREN}, 0);
      chk("rst_dmemWEN", {31'b0, dmemWEN}, 0);
      chk("rst_pc_en", {31'b0, pc_en}, 0);
      chk("rst_halted", {31'b0, halted}, 0);
      chk("rst_stall", {27'b0, stall_cnt}, 0);
      cyc(1, 1, 0, 0, 0, 1, 0);
      chk("rtype_pc_en", {31'b0, pc_en}, 1);
      chk("rtype_stall", {27'b0, stall_cnt}, 1);
      cyc(1, 1, 0, 0, 0, 0, 1);
      chk("idle_dhit_imem", {31'b0, imemREN}, 1);
      chk("idle_dhit_pc_en", {31'b0, pc_en}, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("rtype_after_stall", {27'b0, stall_cnt}, 2);
      rst1();
      cyc(1, 1, 1, 0, 0, 1, 0);
      chk("load_fetch_pc_en", {31'b0, pc_en}, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 1, 0, 1, 0);
         chk("load_wait_ren", {31'b0, dmemREN}, 1);
         chk("load_wait_wen", {31'b0, dmemWEN}, 0);
         chk("load_wait_imem", {31'b0, imemREN}, 0);
      end
      cyc(1, 1, 0, 0, 0, 0, 1);
      chk("load_dhit_pc_en", {31'b0, pc_en}, 1);
      chk("load_dhit_stall", {27'b0, stall_cnt}, 4);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("load_done_ren", {31'b0, dmemREN}, 0);
      chk("load_done_stall", {27'b0, stall_cnt}, 4);
      rst1();
      cyc(1, 1, 1, 1, 0, 1, 0);
      chk("both_err_early", {31'b0, req_err}, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("both_wen", {31'b0, dmemWEN}, 1);
      chk("both_ren", {31'b0, dmemREN}, 0);
      chk("both_err", {31'b0, req_err}, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("both_err_once", {31'b0, req_err}, 0);
      cyc(1, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      rst1();
      cyc(1, 1, 1, 0, 0, 1, 0);
      pulses = 0;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1, 1, 0, 0, 0, 0, 0);
         if (req_err === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
         chk("tout_ren_held", {31'b0, dmemREN}, 1);
      end
      chk("tout_pulses", 32'(pulses), 1);
      chk("tout_pulse_cycle", 32'(first), 5);
      cyc(1, 1, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0);
      rst1();
      cyc(1, 1, 1, 0, 0, 1, 0);
      repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("tout_edge_no_err", {31'b0, req_err}, 0);
      rst1();
      cyc(1, 1, 0, 1, 1, 1, 0);
      chk("halt_pc_en", {31'b0, pc_en}, 0);
      cyc(1, 1, 1, 1, 1, 1, 1);
      chk("halt_halted", {31'b0, halted}, 1);
      chk("halt_err", {31'b0, req_err}, 1);
      chk("halt_imem", {31'b0, imemREN}, 0);
      chk("halt_wen", {31'b0, dmemWEN}, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, i[0], i[1], 0, 1, 1);
         chk("halt_sticky", {31'b0, halted}, 1);
         chk("halt_stall_frozen", {27'b0, stall_cnt}, 1);
      end
      rst1();
      cyc(1, 1, 0, 0, 1, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("halt_plain_err", {31'b0, req_err}, 0);
      chk("halt_plain_halted", {31'b0, halted}, 1);
      rst1();
      cyc(1, 1, 1, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("midrst_ren_before", {31'b0, dmemREN}, 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("midrst_ren", {31'b0, dmemREN}, 0);
      chk("midrst_pc_en", {31'b0, pc_en}, 0);
      chk("midrst_stall", {27'b0, stall_cnt}, 0);
      rst1();
      repeat (40) cyc(1, 1, 0, 0, 0, 0, 0);
      chk("stall_saturate", {27'b0, stall_cnt}, SMAX);
      cyc(1, 1, 0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
